// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM stage.
package pwm_pkg;

   localparam int DEFAULT_WIDTH    = 8;
   localparam int DEFAULT_CHANNELS = 2;

   // Level a pin rests at when its channel is not active (idle, disabled or in reset).
   function automatic logic inactive_level(input bit active_low);
      return active_low;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty value and a registered comparator
// against the shared counter.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic             CP,
   input  logic             RST,
   input  logic             EN,
   input  logic [WIDTH-1:0] cnt,
   input  logic             wrap,
   input  logic             LOAD,
   input  logic             commit,
   input  logic [WIDTH-1:0] duty_in,
   output logic             pwm
);

   logic [WIDTH-1:0] duty_shadow;
   logic [WIDTH-1:0] duty_act;
   logic             take_now;

   // A load that coincides with a commit point skips the shadow entirely.
   assign take_now = LOAD & (wrap | ~EN);

   // NOTE: every state element is assigned with <= so all channels and the
   // shared counter sample the same pre-edge cnt value.
   always_ff @(posedge CP) begin
      if (RST) begin
         duty_shadow <= '0;
         duty_act    <= '0;
         pwm         <= inactive_level(ACTIVE_LOW);
      end else begin
         if (LOAD && !take_now)
            duty_shadow <= duty_in;

         if (take_now)
            duty_act <= duty_in;
         else if (commit)
            duty_act <= duty_shadow;

         if (EN)
            pwm <= (duty_act > cnt) ^ ACTIVE_LOW;
         else
            pwm <= inactive_level(ACTIVE_LOW);
      end
   end

endmodule

// File: rtl/pwm_multi_out.sv
// Multi-channel PWM: shared programmable-period counter, period-end flag and
// glitch-free double-buffered duty/period updates.
module pwm_multi_out
   import pwm_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int CHANNELS   = DEFAULT_CHANNELS,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                      CP,
   input  logic                      RST,
   input  logic                      EN,
   input  logic [WIDTH-1:0]          PERIOD,
   input  logic [CHANNELS*WIDTH-1:0] DUTY_IN,
   input  logic                      LOAD,
   output logic [CHANNELS-1:0]       PWM_OUT,
   output logic                      PERIOD_END,
   output logic                      LOAD_PENDING
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] per_act;
   logic [WIDTH-1:0] per_shadow;
   logic             wrap;
   logic             boundary;
   logic             take_now;
   logic             commit;

   // >= rather than == so a period shortened below cnt still wraps at once.
   assign wrap     = (cnt >= per_act);
   assign boundary = wrap | ~EN;
   assign take_now = LOAD & boundary;
   assign commit   = LOAD_PENDING & boundary;

   always_ff @(posedge CP) begin
      if (RST) begin
         cnt          <= '0;
         per_act      <= '1;
         per_shadow   <= '0;
         LOAD_PENDING <= 1'b0;
         PERIOD_END   <= 1'b0;
      end else begin
         cnt        <= boundary ? '0 : cnt + WIDTH'(1);
         PERIOD_END <= wrap & EN;

         if (LOAD && !take_now) begin
            per_shadow   <= PERIOD;
            LOAD_PENDING <= 1'b1;
         end else if (boundary) begin
            LOAD_PENDING <= 1'b0;
         end

         if (take_now)
            per_act <= PERIOD;
         else if (commit)
            per_act <= per_shadow;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      pwm_channel #(
         .WIDTH      (WIDTH),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .CP      (CP),
         .RST     (RST),
         .EN      (EN),
         .cnt     (cnt),
         .wrap    (wrap),
         .LOAD    (LOAD),
         .commit  (commit),
         .duty_in (DUTY_IN[k*WIDTH +: WIDTH]),
         .pwm     (PWM_OUT[k])
      );
   end

endmodule

// File: tb/tb_pwm_multi_out.sv
// Directed bench for pwm_multi_out (WIDTH=8, CHANNELS=2, ACTIVE_LOW=1).
module tb_pwm_multi_out;

   logic        CP = 1'b0;
   logic        RST;
   logic        EN;
   logic [7:0]  PERIOD;
   logic [15:0] DUTY_IN;
   logic        LOAD;
   logic [1:0]  PWM_OUT;
   logic        PERIOD_END;
   logic        LOAD_PENDING;

   int checks = 0;
   int errors = 0;

   int   low0, low1, pe, pend;
   logic first0, last_pe;

   pwm_multi_out #(
      .WIDTH      (8),
      .CHANNELS   (2),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .CP           (CP),
      .RST          (RST),
      .EN           (EN),
      .PERIOD       (PERIOD),
      .DUTY_IN      (DUTY_IN),
      .LOAD         (LOAD),
      .PWM_OUT      (PWM_OUT),
      .PERIOD_END   (PERIOD_END),
      .LOAD_PENDING (LOAD_PENDING)
   );

   always #5 CP = ~CP;

   task automatic step();
      @(posedge CP);
      #1;
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic set_load(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] per);
      DUTY_IN = {d1, d0};
      PERIOD  = per;
   endtask

   // Runs n cycles and gathers per-cycle statistics of the outputs.
   task automatic run(input int n, output int l0, output int l1, output int npe,
                      output int npend, output logic f0, output logic lpe);
      l0 = 0; l1 = 0; npe = 0; npend = 0; f0 = 1'bx; lpe = 1'bx;
      for (int i = 0; i < n; i++) begin
         step();
         if (PWM_OUT[0] === 1'b0) l0++;
         if (PWM_OUT[1] === 1'b0) l1++;
         if (PERIOD_END === 1'b1) npe++;
         if (LOAD_PENDING === 1'b1) npend++;
         if (i == 0) f0 = PWM_OUT[0];
         if (i == n - 1) lpe = PERIOD_END;
      end
   endtask

   initial begin
      RST = 1'b1; EN = 1'b0; LOAD = 1'b0; PERIOD = 8'd0; DUTY_IN = '0;
      step();
      step();
      check("rst_pwm", int'(PWM_OUT), 3);
      check("rst_pe", int'(PERIOD_END), 0);
      check("rst_pend", int'(LOAD_PENDING), 0);

      // 1: load at cnt=0, commit at the first wrap of the reset period (255)
      RST = 1'b0; EN = 1'b1;
      set_load(8'd64, 8'd0, 8'd255);
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      check("t1_pend_set", int'(LOAD_PENDING), 1);
      run(254, low0, low1, pe, pend, first0, last_pe);
      check("t1_pend_hold", pend, 254);
      check("t1_pe_early", pe, 0);
      step();
      check("t1_pend_clr", int'(LOAD_PENDING), 0);
      check("t1_pe_wrap", int'(PERIOD_END), 1);
      run(256, low0, low1, pe, pend, first0, last_pe);
      check("t1_low0", low0, 64);
      check("t1_low1", low1, 0);
      check("t1_first0", int'(first0), 0);
      check("t1_pe_cnt", pe, 1);
      check("t1_pe_last", int'(last_pe), 1);

      // 2: period 9, duty0 above period (100%), duty1 5 of 10
      set_load(8'd10, 8'd5, 8'd9);
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      run(255, low0, low1, pe, pend, first0, last_pe);
      check("t2_pend", pend, 254);
      check("t2_pe_last", int'(last_pe), 1);
      run(20, low0, low1, pe, pend, first0, last_pe);
      check("t2_low0", low0, 20);
      check("t2_low1", low1, 10);
      check("t2_pe_cnt", pe, 2);

      // 3: install duty0=64 / period 149, then two mid-period loads
      set_load(8'd64, 8'd5, 8'd149);
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      run(9, low0, low1, pe, pend, first0, last_pe);
      check("t3_setup_pend", pend, 8);
      check("t3_setup_pe", int'(last_pe), 1);
      run(3, low0, low1, pe, pend, first0, last_pe);
      set_load(8'd200, 8'd5, 8'd149);
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      run(3, low0, low1, pe, pend, first0, last_pe);
      set_load(8'd100, 8'd5, 8'd149);
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      check("t3_pend", int'(LOAD_PENDING), 1);
      run(142, low0, low1, pe, pend, first0, last_pe);
      check("t3_old_low0", low0, 56);
      check("t3_old_pend", pend, 141);
      check("t3_old_pe", int'(last_pe), 1);
      run(150, low0, low1, pe, pend, first0, last_pe);
      check("t3_new_low0", low0, 100);
      check("t3_new_low1", low1, 5);

      // 4: load exactly in the wrap cycle bypasses the shadow
      run(149, low0, low1, pe, pend, first0, last_pe);
      set_load(8'd30, 8'd5, 8'd149);
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      check("t4_pend", int'(LOAD_PENDING), 0);
      check("t4_pe", int'(PERIOD_END), 1);
      run(150, low0, low1, pe, pend, first0, last_pe);
      check("t4_low0", low0, 30);
      check("t4_pend_cnt", pend, 0);
      check("t4_pe_cnt", pe, 1);

      // 5: disable at cnt=50, load while disabled, re-enable
      run(50, low0, low1, pe, pend, first0, last_pe);
      EN = 1'b0;
      step();
      check("t5_off_pwm", int'(PWM_OUT), 3);
      check("t5_off_pe", int'(PERIOD_END), 0);
      set_load(8'd20, 8'd5, 8'd149);
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      check("t5_off_pend", int'(LOAD_PENDING), 0);
      check("t5_off_pwm2", int'(PWM_OUT), 3);
      EN = 1'b1;
      run(150, low0, low1, pe, pend, first0, last_pe);
      check("t5_low0", low0, 20);
      check("t5_low1", low1, 5);
      check("t5_first0", int'(first0), 0);
      check("t5_pe_last", int'(last_pe), 1);
      check("t5_pe_cnt", pe, 1);

      // 6: reset mid-period discards a pending load
      run(10, low0, low1, pe, pend, first0, last_pe);
      set_load(8'd77, 8'd5, 8'd149);
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      check("t6_pend", int'(LOAD_PENDING), 1);
      run(5, low0, low1, pe, pend, first0, last_pe);
      RST = 1'b1;
      step();
      check("t6_rst_pwm", int'(PWM_OUT), 3);
      check("t6_rst_pend", int'(LOAD_PENDING), 0);
      check("t6_rst_pe", int'(PERIOD_END), 0);
      RST = 1'b0;
      run(256, low0, low1, pe, pend, first0, last_pe);
      check("t6_low0", low0, 0);
      check("t6_low1", low1, 0);
      check("t6_pend_cnt", pend, 0);
      check("t6_pe_cnt", pe, 1);
      check("t6_pe_last", int'(last_pe), 1);

      // 7: PERIOD=0 wraps every cycle; duty 1 is 100%, duty 0 is 0%
      EN = 1'b0;
      set_load(8'd1, 8'd0, 8'd0);
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
      EN = 1'b1;
      run(5, low0, low1, pe, pend, first0, last_pe);
      check("t7_pe_cnt", pe, 5);
      check("t7_low0", low0, 5);
      check("t7_low1", low1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_multi_out.md
Name: pwm_multi_out

Overview:
- Parametrised successor to the single-channel 8-bit audio PWM stage.
- Drives CHANNELS PWM outputs from one shared up-counter with a programmable period.
- Per-channel duty values are double-buffered: a new set is captured on a load strobe and committed only at the period boundary, so no output glitches on a mid-period change.
- Sits between the music-data generator and the speaker/filter pins; adds enable, a period-end flag and a selectable output polarity.

Parameters:
- WIDTH, 8, bit width of counter, period and each duty value.
- CHANNELS, 2, number of independent PWM outputs.
- ACTIVE_LOW, 1, 1: output is 0 while duty > count, 1 otherwise (legacy polarity); 0: inverted.

Ports:
- CP  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  count enable.
- PERIOD  in  WIDTH  terminal count; period length = PERIOD+1 cycles.
- DUTY_IN  in  CHANNELS*WIDTH  packed duty values; channel k = bits [k*WIDTH +: WIDTH].
- LOAD  in  1  one-cycle strobe: capture DUTY_IN and PERIOD into shadow registers.
- PWM_OUT  out  CHANNELS  PWM outputs, registered.
- PERIOD_END  out  1  one-cycle pulse, registered; high the cycle after the counter wraps.
- LOAD_PENDING  out  1  high from the cycle after LOAD until the shadow set is committed.

Behaviour:
- Reset (RST=1 at a CP edge), regardless of other inputs:
  - cnt = 0; per_act = all-ones; duty_act = 0 for all channels; shadow registers = 0.
  - LOAD_PENDING = 0; PERIOD_END = 0.
  - PWM_OUT = inactive level (all-ones if ACTIVE_LOW=1, else all-zeros).
  - Reset mid-period discards any pending load.
- Counter, EN=1: cnt increments each cycle. wrap = (cnt >= per_act). On wrap, cnt <= 0; otherwise cnt <= cnt+1. Modulo arithmetic in WIDTH bits; no overflow beyond per_act.
- Output, EN=1: each edge, active_k = (duty_act[k] > cnt), evaluated with the pre-edge cnt. PWM_OUT[k] <= active_k XOR ACTIVE_LOW. Latency is one cycle from the counter value to the pin.
- Duty boundaries:
  - duty = 0: never active (0%).
  - duty > per_act: always active (100%).
  - duty = d <= per_act: active for exactly d of the (per_act+1) cycles of each period.
- PERIOD_END <= wrap & EN.
- Load/commit:
  - LOAD=1 without wrap in the same cycle: shadow <= {DUTY_IN, PERIOD}; LOAD_PENDING <= 1.
  - Wrap with LOAD_PENDING=1 and LOAD=0: duty_act/per_act <= shadow; LOAD_PENDING <= 0.
  - LOAD=1 in the wrap cycle: DUTY_IN/PERIOD go directly to duty_act/per_act (bypass the shadow); LOAD_PENDING <= 0.
  - LOAD while already pending: the shadow is overwritten; the last value wins.
- EN=0:
  - cnt is forced to 0; PWM_OUT is driven to the inactive level; PERIOD_END = 0.
  - A pending shadow, or a LOAD in the same cycle, commits immediately; LOAD_PENDING <= 0.
  - On EN rising, counting starts from 0 with the new values.
- PERIOD = 0 is legal: wrap occurs every cycle, PERIOD_END stays high, and outputs are 100% when duty >= 1, else 0%.

Decomposition:
- Package pwm_pkg: default WIDTH/CHANNELS constants and the inactive-level function of ACTIVE_LOW.
- Sub-module pwm_channel, one per generate instance: holds the duty shadow and active register plus the registered comparator. Inputs: CP, RST, EN, cnt, wrap, LOAD, commit, duty_in. Output: pwm bit.
- Top level owns the counter, per_act/period shadow, LOAD_PENDING and PERIOD_END.

Test Plan:
1. Reset, then EN=1, PERIOD=255, LOAD with duty0=64, duty1=0 at cnt=0 → LOAD_PENDING high until the wrap. Next full period: ch0 low for 64 cycles and high for 192 (ACTIVE_LOW=1); ch1 constantly high; PERIOD_END pulses every 256 cycles.
2. PERIOD=9, duty0=10, duty1=5 → ch0 100% active; ch1 active 5 of 10 cycles; PERIOD_END every 10 cycles.
3. Mid-period LOAD at cnt=3 (duty0 64→200), then a second LOAD at cnt=7 (duty0=100) → the old duty holds to the period end; the next period uses 100; no runt pulse.
4. LOAD asserted exactly in the wrap cycle with duty0=30 → duty 30 takes effect in the immediately following period; LOAD_PENDING never asserts.
5. EN drops at cnt=50 → cnt=0 and outputs inactive next cycle, PERIOD_END low. LOAD duty0=20 while EN=0, then EN=1 → first period uses 20, starting at cnt 0.
6. RST asserted mid-period with a pending load → next cycle all outputs inactive, LOAD_PENDING=0; after release with EN=1, outputs stay at the inactive level (duty 0) with a 256-cycle period.
